ps2_rx_fifo: RTL

PS/2 device-to-host receiver for the keyboard peripheral. It samples the raw keyboard clock and data pins, deserialises 11-bit PS/2 frames and checks start, parity and stop bits. Valid scancode bytes go into a small show-ahead FIFO with a valid/ready output, which the Avalon keyboard slave and the seven-segment scancode display consume. All logic runs on the system clock; the PS/2 clock is never used as a clock.

---
 rtl/ps2_rx_fifo.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
// PS/2 device-to-host receiver: synchronise and filter the pins, deserialise 11-bit
// frames with start/parity/stop/timeout checks, and queue good bytes in a show-ahead FIFO.
module ps2_rx_fifo #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       csi_clk,
   input  logic       csi_reset_n,
   input  logic       coe_kc,
   input  logic       coe_kd,
   output logic [7:0] code_data,
   output logic       code_valid,
   input  logic       code_ready,
   output logic       frame_err,
   output logic       overflow,
   output logic [4:0] fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = $clog2(FILTER_LEN);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // ------------------------------------------------------------------
   // Input synchronisers (idle line is high, so flops reset to 1)
   // ------------------------------------------------------------------
   logic kc_s1_q, kc_s2_q;
   logic kd_s1_q, kd_s2_q;

   always_ff @(posedge csi_clk or negedge csi_reset_n) begin
      if (!csi_reset_n) begin
         kc_s1_q <= 1'b1;
         kc_s2_q <= 1'b1;
         kd_s1_q <= 1'b1;
         kd_s2_q <= 1'b1;
      end else begin
         kc_s1_q <= coe_kc;
         kc_s2_q <= kc_s1_q;
         kd_s1_q <= coe_kd;
         kd_s2_q <= kd_s1_q;
      end
   end

   // ------------------------------------------------------------------
   // Clock filter: kc_f only follows after FILTER_LEN agreeing samples
   // ------------------------------------------------------------------
   logic          kc_f_q;
   logic          kc_f_dly_q;
   logic [FW-1:0] flt_cnt_q;
   logic          sample;

   always_ff @(posedge csi_clk or negedge csi_reset_n) begin
      if (!csi_reset_n) begin
         kc_f_q     <= 1'b1;
         kc_f_dly_q <= 1'b1;
         flt_cnt_q  <= '0;
      end else begin
         kc_f_dly_q <= kc_f_q;
         if (kc_s2_q != kc_f_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
               kc_f_q    <= kc_s2_q;
               flt_cnt_q <= '0;
            end else begin
               flt_cnt_q <= flt_cnt_q + FW'(1);
            end
         end else begin
            flt_cnt_q <= '0;
         end
      end
   end

   assign sample = kc_f_dly_q & ~kc_f_q;

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t        state_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_q;
   logic          par_q;
   logic [TW-1:0] tmo_cnt_q;
   logic          frame_err_q;
   logic          tmo_hit;
   logic          stop_ok;
   logic          push_req;

   // A sample on the same cycle as the limit keeps the frame alive.
   assign tmo_hit  = (state_q != IDLE) && !sample && (tmo_cnt_q == TW'(TIMEOUT - 1));
   assign stop_ok  = kd_s2_q & (^{shift_q, par_q});
   assign push_req = (state_q == STOP) && sample && stop_ok;

   always_ff @(posedge csi_clk or negedge csi_reset_n) begin
      if (!csi_reset_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         tmo_cnt_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;

         if (state_q == IDLE || sample) begin
            tmo_cnt_q <= '0;
         end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
         end

         if (tmo_hit) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
         end else if (sample) begin
            case (state_q)
               IDLE: begin
                  if (!kd_s2_q) begin
                     state_q   <= DATA;
                     bit_cnt_q <= '0;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
               DATA: begin
                  shift_q   <= {kd_s2_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= PARITY;
                  end
               end
               PARITY: begin
                  par_q   <= kd_s2_q;
                  state_q <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (!stop_ok) begin
                     frame_err_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign frame_err = frame_err_q;

   // ------------------------------------------------------------------
   // Scancode FIFO (pointers carry an extra wrap bit)
   // ------------------------------------------------------------------
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0] level;
   logic        full;
   logic        pop;
   logic        do_push;
   logic        overflow_q;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign full    = (level == (AW+1)'(FIFO_DEPTH));
   assign pop     = code_valid & code_ready;
   assign do_push = push_req & (~full | pop);

   always_ff @(posedge csi_clk or negedge csi_reset_n) begin
      if (!csi_reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= push_req & full & ~pop;
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   // When full with a simultaneous pop the write slot is the head slot; the
   // head is read combinationally this cycle, so the old byte still leaves.
   always_ff @(posedge csi_clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
      end
   end

   assign code_valid = (level != '0);
   assign code_data  = code_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
   assign fifo_level = 5'(level);
   assign overflow   = overflow_q;

endmodule
